// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the MEM/WB pipeline write and a 2-entry queue of
// long-latency (mul/div) results onto one register-file write port.
// Optional starvation guard is enabled by defining WB_STARVE_GUARD_EN.
module wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pipe_reg_write,
  input  logic        pipe_mem_to_reg,
  input  logic [4:0]  pipe_rd,
  input  logic [63:0] pipe_read_data,
  input  logic [63:0] pipe_mem_address,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [63:0] lu_data,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [63:0] rf_wdata,
  output logic        stall_pipe
);

  logic [4:0]  r_q_rd   [2];
  logic [63:0] r_q_data [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;

  logic        w_nonempty;
  logic        w_enq;
  logic        w_deq;
  logic        w_stall;
  logic        w_pipe_wr;
  logic [63:0] w_pipe_data;

  // lu handshake: a result transfers on a cycle where lu_valid && lu_ready;
  // lu_ready depends only on queue occupancy, never on lu_valid.
  assign lu_ready   = (r_count < 2'd2);
  assign w_nonempty = (r_count != 2'd0);
  assign w_enq      = lu_valid && lu_ready && (lu_rd != 5'd0);

`ifdef WB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] r_starve;

  assign w_stall = (r_starve == LIMIT) && w_nonempty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve <= 4'd0;
    end else if (w_deq || !w_nonempty) begin
      r_starve <= 4'd0;
    end else if (r_starve != LIMIT) begin
      r_starve <= r_starve + 4'd1;
    end
  end
`else
  assign w_stall = 1'b0;
`endif

  assign stall_pipe  = w_stall;
  assign w_pipe_data = pipe_mem_to_reg ? pipe_read_data : pipe_mem_address;
  assign w_pipe_wr   = !w_stall && pipe_reg_write && (pipe_rd != 5'd0);
  // A stall cycle forces w_pipe_wr low, so the head drains in that cycle.
  assign w_deq       = w_nonempty && !w_pipe_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q_rd[0]   <= 5'd0;
      r_q_rd[1]   <= 5'd0;
      r_q_data[0] <= 64'd0;
      r_q_data[1] <= 64'd0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      if (w_enq) begin
        r_q_rd[r_wr_ptr]   <= lu_rd;
        r_q_data[r_wr_ptr] <= lu_data;
        r_wr_ptr           <= ~r_wr_ptr;
      end
      if (w_deq) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we    <= 1'b0;
      rf_rd    <= 5'd0;
      rf_wdata <= 64'd0;
    end else if (w_pipe_wr) begin
      rf_we    <= 1'b1;
      rf_rd    <= pipe_rd;
      rf_wdata <= w_pipe_data;
    end else if (w_deq) begin
      rf_we    <= 1'b1;
      rf_rd    <= r_q_rd[r_rd_ptr];
      rf_wdata <= r_q_data[r_rd_ptr];
    end else begin
      rf_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by random traffic, all
// checked against a queue-based reference model of the writeback rules.
module tb_wb_arbiter;

  localparam int LIMIT = 4;
`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pipe_reg_write, pipe_mem_to_reg;
  logic [4:0]  pipe_rd;
  logic [63:0] pipe_read_data, pipe_mem_address;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [63:0] lu_data;
  logic        lu_ready, rf_we, stall_pipe;
  logic [4:0]  rf_rd;
  logic [63:0] rf_wdata;

  wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .pipe_reg_write(pipe_reg_write), .pipe_mem_to_reg(pipe_mem_to_reg),
    .pipe_rd(pipe_rd), .pipe_read_data(pipe_read_data),
    .pipe_mem_address(pipe_mem_address),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data),
    .lu_ready(lu_ready), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .stall_pipe(stall_pipe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // reference model: pending long-latency results as {rd, data}
  logic [68:0] exp_q[$];
  int          m_starve;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [63:0] m_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_starve = 0;
    m_we     = 1'b0;
    m_rd     = 5'd0;
    m_wdata  = 64'd0;
  endtask

  task automatic set_pipe(input logic we, input logic m2r, input logic [4:0] rd,
                          input logic [63:0] rdata, input logic [63:0] addr);
    pipe_reg_write   = we;
    pipe_mem_to_reg  = m2r;
    pipe_rd          = rd;
    pipe_read_data   = rdata;
    pipe_mem_address = addr;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] rd, input logic [63:0] d);
    lu_valid = v;
    lu_rd    = rd;
    lu_data  = d;
  endtask

  // Called #1 after a rising edge with inputs already applied: checks the
  // state-only outputs, advances the model, crosses one edge, checks rf_*.
  task automatic cycle();
    bit          stall_e, ready_e, pipe_wr, deq;
    int          sz;
    logic [68:0] head;
    sz      = exp_q.size();
    stall_e = GUARD && (m_starve == LIMIT) && (sz > 0);
    ready_e = (sz < 2);
    chk("stall_pipe", 64'(stall_pipe), 64'(stall_e));
    chk("lu_ready", 64'(lu_ready), 64'(ready_e));
    pipe_wr = !stall_e && pipe_reg_write && (pipe_rd != 5'd0);
    deq     = (sz > 0) && !pipe_wr;
    if (pipe_wr) begin
      m_we    = 1'b1;
      m_rd    = pipe_rd;
      m_wdata = pipe_mem_to_reg ? pipe_read_data : pipe_mem_address;
    end else if (deq) begin
      head    = exp_q.pop_front();
      m_we    = 1'b1;
      m_rd    = head[68:64];
      m_wdata = head[63:0];
    end else begin
      m_we = 1'b0;
    end
    if (GUARD) begin
      if (deq || sz == 0) m_starve = 0;
      else if (m_starve < LIMIT) m_starve = m_starve + 1;
    end
    if (lu_valid && ready_e && lu_rd != 5'd0) exp_q.push_back({lu_rd, lu_data});
    @(posedge clk);
    #1;
    chk("rf_we", 64'(rf_we), 64'(m_we));
    chk("rf_rd", 64'(rf_rd), 64'(m_rd));
    chk("rf_wdata", rf_wdata, m_wdata);
  endtask

  initial begin
    // reset
    reset_n = 1'b1;
    set_pipe(1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
    set_lu(1'b0, 5'd0, 64'd0);
    model_reset();
    #1 reset_n = 1'b0;
    #1;
    chk("reset_rf_we", 64'(rf_we), 64'd0);
    chk("reset_rf_rd", 64'(rf_rd), 64'd0);
    chk("reset_rf_wdata", rf_wdata, 64'd0);
    chk("reset_lu_ready", 64'(lu_ready), 64'd1);
    chk("reset_stall", 64'(stall_pipe), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    cycle();

    // pipeline-only write of load data
    set_pipe(1'b1, 1'b1, 5'd5, 64'hAA, 64'($urandom));
    cycle();
    chk("pipe_we", 64'(rf_we), 64'd1);
    chk("pipe_rd", 64'(rf_rd), 64'd5);
    chk("pipe_wdata", rf_wdata, 64'hAA);
    // ALU result path
    set_pipe(1'b1, 1'b0, 5'd9, 64'h1, 64'hDEAD_BEEF);
    cycle();
    chk("alu_wdata", rf_wdata, 64'hDEAD_BEEF);
    set_pipe(1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
    cycle();

    // idle-slot drain: 2-cycle latency
    set_lu(1'b1, 5'd7, 64'h1234);
    cycle();
    set_lu(1'b0, 5'd0, 64'd0);
    chk("drain_not_early", 64'(rf_we), 64'd0);
    cycle();
    chk("drain_we", 64'(rf_we), 64'd1);
    chk("drain_rd", 64'(rf_rd), 64'd7);
    chk("drain_wdata", rf_wdata, 64'h1234);
    cycle();

    // backpressure while the pipe writes every cycle
    set_pipe(1'b1, 1'b1, 5'd3, 64'h300, 64'd0);
    set_lu(1'b1, 5'd10, 64'hA0);
    cycle();
    set_lu(1'b1, 5'd11, 64'hA1);
    cycle();
    set_lu(1'b1, 5'd12, 64'hA2);
    chk("bp_ready_low", 64'(lu_ready), 64'd0);
    cycle();
    set_pipe(1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
    cycle();
    cycle();
    set_lu(1'b0, 5'd0, 64'd0);
    for (int i = 0; i < 4; i++) cycle();
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

`ifdef WB_STARVE_GUARD_EN
    // starvation guard: one queued entry against a continuously writing pipe
    set_pipe(1'b1, 1'b1, 5'd4, 64'h44, 64'd0);
    set_lu(1'b1, 5'd20, 64'h2020);
    cycle();
    set_lu(1'b0, 5'd0, 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("starve_no_stall", 64'(stall_pipe), 64'd0);
      cycle();
    end
    chk("starve_stall", 64'(stall_pipe), 64'd1);
    cycle();
    chk("starve_head_rd", 64'(rf_rd), 64'd20);
    chk("starve_head_data", rf_wdata, 64'h2020);
    chk("starve_released", 64'(stall_pipe), 64'd0);
    cycle();
    chk("starve_pipe_rd", 64'(rf_rd), 64'd4);
    set_pipe(1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
    cycle();
`endif

    // x0 result is accepted but dropped
    set_lu(1'b1, 5'd0, 64'hBAD);
    cycle();
    set_lu(1'b0, 5'd0, 64'd0);
    chk("x0_ready", 64'(lu_ready), 64'd1);
    cycle();
    chk("x0_no_write", 64'(rf_we), 64'd0);

    // mid-operation reset with two entries queued
    set_pipe(1'b1, 1'b0, 5'd6, 64'd0, 64'h66);
    set_lu(1'b1, 5'd13, 64'hC0);
    cycle();
    set_lu(1'b1, 5'd14, 64'hC1);
    cycle();
    set_lu(1'b0, 5'd0, 64'd0);
    chk("full_before_reset", 64'(lu_ready), 64'd0);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_reset_we", 64'(rf_we), 64'd0);
    chk("mid_reset_rd", 64'(rf_rd), 64'd0);
    chk("mid_reset_wdata", rf_wdata, 64'd0);
    chk("mid_reset_ready", 64'(lu_ready), 64'd1);
    chk("mid_reset_stall", 64'(stall_pipe), 64'd0);
    model_reset();
    set_pipe(1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_pipe(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), {32'($urandom), 32'($urandom)},
               {32'($urandom), 32'($urandom)});
      set_lu(1'($urandom_range(0, 99) < 40), 5'($urandom_range(0, 31)),
             {32'($urandom), 32'($urandom)});
      cycle();
    end
    set_pipe(1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
    set_lu(1'b0, 5'd0, 64'd0);
    for (int i = 0; i < 4; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
